// File: rtl/axilite_rr_master.sv
// Two-client AXI-Lite master: round-robin grant, one single-beat transaction in flight,
// watchdog abort on a stalled slave. Every output is a register.
module axilite_rr_master #(
   parameter int TIMEOUT = 64
) (
   input  logic        m_axi_aclk,
   input  logic        m_axi_areset,
   input  logic [1:0]  req_valid,
   input  logic [1:0]  req_write,
   input  logic [63:0] req_addr,
   input  logic [63:0] req_wdata,
   output logic [1:0]  req_accept,
   output logic [1:0]  rsp_valid,
   output logic [31:0] rsp_rdata,
   output logic [1:0]  rsp_resp,
   output logic        timeout_err,
   output logic        m_axi_awvalid,
   output logic [31:0] m_axi_awaddr,
   input  logic        m_axi_awready,
   output logic        m_axi_wvalid,
   output logic [31:0] m_axi_wdata,
   input  logic        m_axi_wready,
   input  logic        m_axi_bvalid,
   input  logic [1:0]  m_axi_bresp,
   output logic        m_axi_bready,
   output logic        m_axi_arvalid,
   output logic [31:0] m_axi_araddr,
   input  logic        m_axi_arready,
   input  logic        m_axi_rvalid,
   input  logic [31:0] m_axi_rdata,
   input  logic [1:0]  m_axi_rresp,
   output logic        m_axi_rready,
   output logic [2:0]  dbg_state
);

   // A beat transfers on a rising edge where valid and ready are both high; valid is
   // never withdrawn before that edge and drops in the cycle right after it.
   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_WR      = 3'd1,
      S_WR_RESP = 3'd2,
      S_RD_ADDR = 3'd3,
      S_RD_DATA = 3'd4,
      S_DONE    = 3'd5
   } state_t;

   state_t      r_state, w_state_nxt;
   logic        r_last_grant, w_last_grant_nxt;
   logic        r_grant, w_grant_nxt;
   logic [31:0] r_addr, w_addr_nxt;
   logic [31:0] r_wdata, w_wdata_nxt;
   logic [15:0] r_cnt, w_cnt_nxt;
   logic [1:0]  r_req_accept, w_req_accept_nxt;
   logic [1:0]  r_rsp_valid, w_rsp_valid_nxt;
   logic [31:0] r_rsp_rdata, w_rsp_rdata_nxt;
   logic [1:0]  r_rsp_resp, w_rsp_resp_nxt;
   logic        r_timeout_err, w_timeout_err_nxt;
   logic        r_awvalid, w_awvalid_nxt;
   logic        r_wvalid, w_wvalid_nxt;
   logic        r_bready, w_bready_nxt;
   logic        r_arvalid, w_arvalid_nxt;
   logic        r_rready, w_rready_nxt;
   logic        w_sel, w_waiting, w_progress;
   logic        w_aw_hs, w_w_hs, w_b_hs, w_ar_hs, w_r_hs, w_expired;

   assign w_aw_hs   = r_awvalid & m_axi_awready;
   assign w_w_hs    = r_wvalid  & m_axi_wready;
   assign w_b_hs    = r_bready  & m_axi_bvalid;
   assign w_ar_hs   = r_arvalid & m_axi_arready;
   assign w_r_hs    = r_rready  & m_axi_rvalid;
   // This stalled cycle would bring the wait count up to TIMEOUT.
   assign w_expired = ({1'b0, r_cnt} + 17'd1) >= 17'(TIMEOUT);

   always_comb begin
      w_state_nxt       = r_state;
      w_last_grant_nxt  = r_last_grant;
      w_grant_nxt       = r_grant;
      w_addr_nxt        = r_addr;
      w_wdata_nxt       = r_wdata;
      w_cnt_nxt         = r_cnt;
      w_req_accept_nxt  = 2'b00;
      w_rsp_valid_nxt   = 2'b00;
      w_rsp_rdata_nxt   = r_rsp_rdata;
      w_rsp_resp_nxt    = r_rsp_resp;
      w_timeout_err_nxt = r_timeout_err;
      w_awvalid_nxt     = r_awvalid;
      w_wvalid_nxt      = r_wvalid;
      w_bready_nxt      = r_bready;
      w_arvalid_nxt     = r_arvalid;
      w_rready_nxt      = r_rready;
      w_sel             = 1'b0;
      w_waiting         = 1'b0;
      w_progress        = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (|req_valid) begin
               if (&req_valid) begin
                  w_sel            = ~r_last_grant;
                  w_last_grant_nxt = ~r_last_grant;
               end else begin
                  w_sel = req_valid[1];
               end
               w_grant_nxt      = w_sel;
               w_req_accept_nxt = w_sel ? 2'b10 : 2'b01;
               w_addr_nxt       = w_sel ? req_addr[63:32]  : req_addr[31:0];
               w_wdata_nxt      = w_sel ? req_wdata[63:32] : req_wdata[31:0];
               w_cnt_nxt        = '0;
               if (req_write[w_sel]) begin
                  w_state_nxt   = S_WR;
                  w_awvalid_nxt = 1'b1;
                  w_wvalid_nxt  = 1'b1;
               end else begin
                  w_state_nxt   = S_RD_ADDR;
                  w_arvalid_nxt = 1'b1;
               end
            end
         end
         S_WR: begin
            w_waiting  = 1'b1;
            w_progress = w_aw_hs | w_w_hs;
            if (w_aw_hs) w_awvalid_nxt = 1'b0;
            if (w_w_hs)  w_wvalid_nxt  = 1'b0;
            if ((!r_awvalid || w_aw_hs) && (!r_wvalid || w_w_hs)) begin
               w_state_nxt  = S_WR_RESP;
               w_bready_nxt = 1'b1;
            end
         end
         S_WR_RESP: begin
            w_waiting  = 1'b1;
            w_progress = w_b_hs;
            if (w_b_hs) begin
               w_rsp_resp_nxt  = m_axi_bresp;
               w_rsp_rdata_nxt = '0;
               w_bready_nxt    = 1'b0;
               w_state_nxt     = S_DONE;
            end
         end
         S_RD_ADDR: begin
            w_waiting  = 1'b1;
            w_progress = w_ar_hs;
            if (w_ar_hs) begin
               w_arvalid_nxt = 1'b0;
               w_rready_nxt  = 1'b1;
               w_state_nxt   = S_RD_DATA;
            end
         end
         S_RD_DATA: begin
            w_waiting  = 1'b1;
            w_progress = w_r_hs;
            if (w_r_hs) begin
               w_rsp_rdata_nxt = m_axi_rdata;
               w_rsp_resp_nxt  = m_axi_rresp;
               w_rready_nxt    = 1'b0;
               w_state_nxt     = S_DONE;
            end
         end
         S_DONE: begin
            w_rsp_valid_nxt = r_grant ? 2'b10 : 2'b01;
            w_state_nxt     = S_IDLE;
         end
         default: w_state_nxt = S_IDLE;
      endcase
      // Watchdog: any handshake restarts the count; a stall that reaches TIMEOUT aborts.
      if (w_waiting) begin
         if (w_progress) begin
            w_cnt_nxt = '0;
         end else if (w_expired) begin
            w_awvalid_nxt     = 1'b0;
            w_wvalid_nxt      = 1'b0;
            w_bready_nxt      = 1'b0;
            w_arvalid_nxt     = 1'b0;
            w_rready_nxt      = 1'b0;
            w_rsp_resp_nxt    = 2'b10;
            w_rsp_rdata_nxt   = '0;
            w_timeout_err_nxt = 1'b1;
            w_state_nxt       = S_DONE;
         end else begin
            w_cnt_nxt = r_cnt + 16'd1;
         end
      end
   end

   always_ff @(posedge m_axi_aclk) begin
      if (m_axi_areset) begin
         r_state       <= S_IDLE;
         r_last_grant  <= 1'b1;
         r_grant       <= 1'b0;
         r_addr        <= '0;
         r_wdata       <= '0;
         r_cnt         <= '0;
         r_req_accept  <= '0;
         r_rsp_valid   <= '0;
         r_rsp_rdata   <= '0;
         r_rsp_resp    <= '0;
         r_timeout_err <= 1'b0;
         r_awvalid     <= 1'b0;
         r_wvalid      <= 1'b0;
         r_bready      <= 1'b0;
         r_arvalid     <= 1'b0;
         r_rready      <= 1'b0;
      end else begin
         r_state       <= w_state_nxt;
         r_last_grant  <= w_last_grant_nxt;
         r_grant       <= w_grant_nxt;
         r_addr        <= w_addr_nxt;
         r_wdata       <= w_wdata_nxt;
         r_cnt         <= w_cnt_nxt;
         r_req_accept  <= w_req_accept_nxt;
         r_rsp_valid   <= w_rsp_valid_nxt;
         r_rsp_rdata   <= w_rsp_rdata_nxt;
         r_rsp_resp    <= w_rsp_resp_nxt;
         r_timeout_err <= w_timeout_err_nxt;
         r_awvalid     <= w_awvalid_nxt;
         r_wvalid      <= w_wvalid_nxt;
         r_bready      <= w_bready_nxt;
         r_arvalid     <= w_arvalid_nxt;
         r_rready      <= w_rready_nxt;
      end
   end

   assign req_accept    = r_req_accept;
   assign rsp_valid     = r_rsp_valid;
   assign rsp_rdata     = r_rsp_rdata;
   assign rsp_resp      = r_rsp_resp;
   assign timeout_err   = r_timeout_err;
   assign m_axi_awvalid = r_awvalid;
   assign m_axi_awaddr  = r_addr;
   assign m_axi_wvalid  = r_wvalid;
   assign m_axi_wdata   = r_wdata;
   assign m_axi_bready  = r_bready;
   assign m_axi_arvalid = r_arvalid;
   assign m_axi_araddr  = r_addr;
   assign m_axi_rready  = r_rready;
   assign dbg_state     = r_state;

endmodule

// File: tb/tb_axilite_rr_master.sv
// Bench for axilite_rr_master: two client drivers, a 128-word AXI-Lite slave with
// programmable stalls, and a response scoreboard fed from a memory reference model.
module tb_axilite_rr_master;

   localparam int TMO = 8;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   logic [1:0]  req_valid, req_write, req_accept, rsp_valid, rsp_resp;
   logic [63:0] req_addr, req_wdata;
   logic [31:0] rsp_rdata, awaddr, wdata, araddr, rdata;
   logic        timeout_err, awvalid, awready, wvalid, wready, bvalid, bready;
   logic        arvalid, arready, rvalid, rready;
   logic [1:0]  bresp, rresp;
   logic [2:0]  dbg_state;

   axilite_rr_master #(.TIMEOUT(TMO)) dut (
      .m_axi_aclk(clk), .m_axi_areset(rst),
      .req_valid(req_valid), .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
      .req_accept(req_accept), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_resp(rsp_resp),
      .timeout_err(timeout_err),
      .m_axi_awvalid(awvalid), .m_axi_awaddr(awaddr), .m_axi_awready(awready),
      .m_axi_wvalid(wvalid), .m_axi_wdata(wdata), .m_axi_wready(wready),
      .m_axi_bvalid(bvalid), .m_axi_bresp(bresp), .m_axi_bready(bready),
      .m_axi_arvalid(arvalid), .m_axi_araddr(araddr), .m_axi_arready(arready),
      .m_axi_rvalid(rvalid), .m_axi_rdata(rdata), .m_axi_rresp(rresp), .m_axi_rready(rready),
      .dbg_state(dbg_state)
   );

   typedef struct packed {
      logic        write;
      logic [31:0] addr;
      logic [31:0] wdata;
   } req_t;

   int          checks = 0;
   int          failures = 0;
   req_t        cq0[$], cq1[$];
   logic [34:0] exp_q[$];            // {client, resp, rdata}
   int          grant_q[$];
   logic [31:0] model_mem [128];
   logic [31:0] slv_mem [128];
   logic [1:0]  drv_act = 2'b00;
   logic        dead = 1'b0;
   logic        rand_mode = 1'b0;
   int          aw_dly = 0, w_dly = 0, b_dly = 0, ar_dly = 0, r_dly = 0;
   int          cyc = 0, aw_hs_cyc = 0, w_hs_cyc = 0, b_rise_cyc = 0, ar_abort_len = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h at cycle %0d", name, act, exp, cyc);
      end
   endtask

   // ---------------- client drivers + reference model ----------------
   initial begin : driver
      req_t cur[2];
      logic a, g, both, model_last;
      logic [34:0] e;
      req_valid = '0; req_write = '0; req_addr = '0; req_wdata = '0;
      cur[0] = '0; cur[1] = '0;
      model_last = 1'b1;
      forever begin
         @(negedge clk);
         if (rst) begin
            drv_act = 2'b00;
            model_last = 1'b1;
         end else begin
            if (req_accept != 2'b00) begin
               both = drv_act[0] & drv_act[1];
               g = both ? ~model_last : ~drv_act[0];
               if (both) model_last = g;
               check("grant", 64'(req_accept), g ? 64'd2 : 64'd1);
               a = req_accept[1];
               if (dead && !cur[a].write)       e = {a, 2'b10, 32'h0};
               else if (cur[a].addr >= 32'h200) e = {a, 2'b11, 32'h0};
               else if (cur[a].write) begin
                  model_mem[cur[a].addr[8:2]] = cur[a].wdata;
                  e = {a, 2'b00, 32'h0};
               end else e = {a, 2'b00, model_mem[cur[a].addr[8:2]]};
               exp_q.push_back(e);
               grant_q.push_back(int'(a));
               drv_act[a] = 1'b0;
            end
            if (!drv_act[0] && cq0.size() != 0) begin cur[0] = cq0.pop_front(); drv_act[0] = 1'b1; end
            if (!drv_act[1] && cq1.size() != 0) begin cur[1] = cq1.pop_front(); drv_act[1] = 1'b1; end
         end
         req_valid = drv_act;
         req_write = {cur[1].write, cur[0].write};
         req_addr  = {cur[1].addr, cur[0].addr};
         req_wdata = {cur[1].wdata, cur[0].wdata};
      end
   end

   // ---------------- slave: handshake capture and protocol checks ----------------
   logic aw_have = 0, w_have = 0, b_busy = 0, ar_have = 0, r_busy = 0;
   logic [31:0] aw_addr_s, w_data_s, ar_addr_s;
   initial begin : slave_sample
      logic aw_p, w_p, ar_p, br_p;
      int ar_run;
      aw_p = 0; w_p = 0; ar_p = 0; br_p = 0; ar_run = 0;
      forever begin
         @(posedge clk);
         if (rst) begin
            aw_have = 0; w_have = 0; b_busy = 0; ar_have = 0; r_busy = 0;
            aw_p = 0; w_p = 0; ar_p = 0; br_p = 0; ar_run = 0;
         end else begin
            if (aw_p) check("awvalid_drop", 64'(awvalid), 64'd0);
            if (w_p)  check("wvalid_drop", 64'(wvalid), 64'd0);
            if (ar_p) check("arvalid_drop", 64'(arvalid), 64'd0);
            if (arvalid) check("rd_wr_exclusive", 64'(awvalid | wvalid | bready), 64'd0);
            aw_p = awvalid & awready;
            w_p  = wvalid & wready;
            ar_p = arvalid & arready;
            if (aw_p) begin aw_have = 1; aw_addr_s = awaddr; aw_hs_cyc = cyc; end
            if (w_p)  begin w_have = 1; w_data_s = wdata; w_hs_cyc = cyc; end
            if (bvalid && bready) begin aw_have = 0; w_have = 0; b_busy = 0; end
            if (ar_p) begin ar_have = 1; ar_addr_s = araddr; end
            if (rvalid && rready) begin ar_have = 0; r_busy = 0; end
            if (bready && !br_p) b_rise_cyc = cyc;
            br_p = bready;
            if (arvalid) ar_run = arready ? 0 : ar_run + 1;
            else if (ar_run != 0) begin ar_abort_len = ar_run; ar_run = 0; end
         end
         cyc++;
      end
   end

   // ---------------- slave: ready/valid drive on the falling edge ----------------
   initial begin : slave_drive
      int aw_c, w_c, b_c, ar_c, r_c;
      aw_c = 0; w_c = 0; b_c = 0; ar_c = 0; r_c = 0;
      awready = 0; wready = 0; bvalid = 0; bresp = 0; arready = 0; rvalid = 0; rdata = 0; rresp = 0;
      forever begin
         @(negedge clk);
         if (rst) begin
            awready = 0; wready = 0; bvalid = 0; arready = 0; rvalid = 0;
            aw_c = 0; w_c = 0; b_c = 0; ar_c = 0; r_c = 0;
         end else begin
            if (rand_mode && !awvalid) aw_dly = $urandom_range(0, 4);
            if (rand_mode && !wvalid)  w_dly  = $urandom_range(0, 4);
            if (rand_mode && !arvalid) ar_dly = $urandom_range(0, 4);
            awready = 0;
            if (awvalid && !aw_have) begin
               if (aw_c >= aw_dly) awready = 1; else aw_c++;
            end else aw_c = 0;
            wready = 0;
            if (wvalid && !w_have) begin
               if (w_c >= w_dly) wready = 1; else w_c++;
            end else w_c = 0;
            arready = 0;
            if (arvalid && !ar_have && !dead) begin
               if (ar_c >= ar_dly) arready = 1; else ar_c++;
            end else ar_c = 0;
            if (!b_busy) bvalid = 0;
            if (aw_have && w_have && !b_busy) begin
               b_busy = 1; b_c = 0;
               if (rand_mode) b_dly = $urandom_range(0, 4);
               if (aw_addr_s < 32'h200) begin slv_mem[aw_addr_s[8:2]] = w_data_s; bresp = 2'b00; end
               else bresp = 2'b11;
            end
            if (b_busy && !bvalid) begin
               if (b_c >= b_dly) bvalid = 1; else b_c++;
            end
            if (!r_busy) rvalid = 0;
            if (ar_have && !r_busy) begin
               r_busy = 1; r_c = 0;
               if (rand_mode) r_dly = $urandom_range(0, 4);
               if (ar_addr_s < 32'h200) begin rdata = slv_mem[ar_addr_s[8:2]]; rresp = 2'b00; end
               else begin rdata = 32'h0; rresp = 2'b11; end
            end
            if (r_busy && !rvalid) begin
               if (r_c >= r_dly) rvalid = 1; else r_c++;
            end
         end
      end
   end

   // ---------------- scoreboard monitor ----------------
   initial begin : monitor
      logic [1:0]  prev_rsp;
      logic        exp_tmo;
      logic [34:0] e;
      prev_rsp = 0; exp_tmo = 0;
      forever begin
         @(negedge clk);
         if (rst) begin
            exp_q.delete();
            exp_tmo = 0;
         end else if (rsp_valid != 2'b00) begin
            check("rsp_single_cycle", 64'(prev_rsp), 64'd0);
            if (exp_q.size() == 0) begin
               checks++; failures++;
               $display("FAIL rsp_unexpected actual=%0h required=none at cycle %0d", rsp_valid, cyc);
            end else begin
               e = exp_q.pop_front();
               check("rsp_client", 64'(rsp_valid), e[34] ? 64'd2 : 64'd1);
               check("rsp_resp", 64'(rsp_resp), 64'(e[33:32]));
               check("rsp_rdata", 64'(rsp_rdata), 64'(e[31:0]));
               if (e[33:32] == 2'b10) exp_tmo = 1;
               check("timeout_err", 64'(timeout_err), 64'(exp_tmo));
            end
         end
         prev_rsp = rsp_valid;
      end
   end

   task automatic drain(input int budget);
      int n;
      n = 0;
      while ((cq0.size() != 0 || cq1.size() != 0 || drv_act != 2'b00 || exp_q.size() != 0) && n < budget) begin
         @(negedge clk);
         n++;
      end
      checks++;
      if (n >= budget) begin
         failures++;
         $display("FAIL drain_timeout actual=%0d pending required=0 pending", exp_q.size());
      end
      repeat (2) @(negedge clk);
   endtask

   function automatic req_t mk(input logic w, input logic [31:0] a, input logic [31:0] d);
      req_t r;
      r.write = w; r.addr = a; r.wdata = d;
      return r;
   endfunction

   initial begin : global_watchdog
      #500000;
      $display("FAIL global_timeout actual=running required=finished");
      $fatal(1, "bench stalled");
   end

   // ---------------- main sequence ----------------
   initial begin : main
      int n;
      req_t r;
      for (int i = 0; i < 128; i++) begin model_mem[i] = '0; slv_mem[i] = '0; end
      aw_dly = 1; w_dly = 0; b_dly = 1; ar_dly = 1; r_dly = 1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_ctrl", 64'({req_accept, rsp_valid, rsp_resp, timeout_err, awvalid, wvalid, bready, arvalid, rready}), 64'd0);
      check("rst_data", {rsp_rdata, awaddr}, 64'd0);
      check("rst_state", 64'(dbg_state), 64'd0);
      rst = 0;

      // single write then read-back from the other client
      @(posedge clk);
      cq0.push_back(mk(1'b1, 32'h10, 32'hDEADBEEF));
      drain(200);
      cq1.push_back(mk(1'b0, 32'h10, 32'h0));
      drain(200);

      // contention: both clients always pending
      grant_q.delete();
      @(posedge clk);
      for (int i = 0; i < 3; i++) begin
         cq0.push_back(mk(1'b0, 32'h10, 32'h0));
         cq1.push_back(mk(1'b0, 32'(4 * i), 32'h0));
      end
      drain(400);
      check("cont_count", 64'(grant_q.size()), 64'd6);
      for (int i = 0; i < 6 && i < grant_q.size(); i++) check("cont_order", 64'(grant_q[i]), 64'(i % 2));

      // out-of-range write and read
      @(posedge clk);
      cq1.push_back(mk(1'b1, 32'h200, 32'h12345678));
      drain(200);
      cq1.push_back(mk(1'b0, 32'h200, 32'h0));
      drain(200);

      // split write handshake
      aw_dly = 0; w_dly = 3; b_dly = 1;
      @(posedge clk);
      cq0.push_back(mk(1'b1, 32'h20, 32'hCAFEF00D));
      drain(200);
      check("split_gap", 64'(w_hs_cyc - aw_hs_cyc), 64'd3);
      check("bready_rise", 64'(b_rise_cyc), 64'(w_hs_cyc + 1));

      // read address never accepted -> watchdog abort
      dead = 1;
      @(posedge clk);
      cq0.push_back(mk(1'b0, 32'h20, 32'h0));
      drain(200);
      check("ar_abort_len", 64'(ar_abort_len), 64'(TMO));
      dead = 0;
      cq1.push_back(mk(1'b0, 32'h20, 32'h0));
      drain(200);
      check("timeout_sticky", 64'(timeout_err), 64'd1);

      // randomized traffic over a small address window plus some out-of-range
      rand_mode = 1;
      for (int i = 0; i < 60; i++) begin
         r.write = 1'($urandom_range(0, 1));
         r.addr  = ($urandom_range(0, 7) == 0) ? 32'h200 + (32'($urandom_range(0, 63)) << 2)
                                              : (32'($urandom_range(0, 15)) << 2);
         r.wdata = $urandom;
         if ($urandom_range(0, 1) == 1) cq1.push_back(r); else cq0.push_back(r);
         if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 20)) @(posedge clk);
      end
      drain(6000);

      // reset while waiting for read data
      rand_mode = 0; ar_dly = 0; r_dly = 6;
      @(posedge clk);
      cq0.push_back(mk(1'b0, 32'h10, 32'h0));
      n = 0;
      while (rready !== 1'b1 && n < 50) begin @(negedge clk); n++; end
      checks++;
      if (n >= 50) begin failures++; $display("FAIL rready_wait actual=0 required=1"); end
      rst = 1;
      @(negedge clk);
      check("midrst_ctrl", 64'({req_accept, rsp_valid, rsp_resp, timeout_err, awvalid, wvalid, bready, arvalid, rready}), 64'd0);
      check("midrst_data", {rsp_rdata, araddr}, 64'd0);
      @(negedge clk);
      rst = 0;
      r_dly = 1;
      grant_q.delete();
      @(posedge clk);
      cq0.push_back(mk(1'b0, 32'h10, 32'h0));
      cq1.push_back(mk(1'b0, 32'h14, 32'h0));
      drain(300);
      check("post_rst_count", 64'(grant_q.size()), 64'd2);
      if (grant_q.size() != 0) check("post_rst_first", 64'(grant_q[0]), 64'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/axilite_rr_master.md
Name: axilite_rr_master

Overview:
- Two-requester AXI-Lite master that shares one AXI-Lite slave (the 128-word register/memory slave) between two internal clients.
- Round-robin arbitration between the clients; one transaction outstanding at a time.
- Each transaction is a single write or a single read. A watchdog aborts transactions the slave never completes.

Parameters:
- TIMEOUT, 64, maximum cycles spent waiting in any AXI wait state before the transaction is aborted (valid range 2..65535).

Ports:
- m_axi_aclk  in  1  clock
- m_axi_areset  in  1  synchronous, active-high reset
- req_valid  in  2  per-client request strobe; held until accepted
- req_write  in  2  per-client: 1 = write, 0 = read
- req_addr  in  64  client i address at [32*i+31:32*i]
- req_wdata  in  64  client i write data at [32*i+31:32*i]
- req_accept  out  2  one-cycle pulse; the request was latched
- rsp_valid  out  2  one-cycle pulse; the transaction finished
- rsp_rdata  out  32  read data (0 for writes), valid with rsp_valid
- rsp_resp  out  2  AXI response, or 2'b10 on timeout
- timeout_err  out  1  sticky; set on any timeout; cleared only by reset
- m_axi_awvalid, m_axi_awaddr[31:0], m_axi_wvalid, m_axi_wdata[31:0], m_axi_bready  out  AXI-Lite write channels
- m_axi_awready, m_axi_wready, m_axi_bvalid, m_axi_bresp[1:0]  in
- m_axi_arvalid, m_axi_araddr[31:0], m_axi_rready  out  AXI-Lite read channels
- m_axi_arready, m_axi_rvalid, m_axi_rdata[31:0], m_axi_rresp[1:0]  in

Behaviour:
- Reset:
  - All outputs are 0 and the state is IDLE.
  - last_grant is 1, so client 0 wins the first tie.
  - The wait counter is 0 and timeout_err is 0.
  - Reset mid-transaction drops all valids on the next edge; no rsp_valid is issued.
- Registered outputs: every output is registered.
- IDLE:
  - If exactly one req_valid bit is set, grant that client.
  - If both bits are set, grant !last_grant, then update last_grant.
  - On grant: pulse req_accept[g]; latch addr, wdata and write; clear the counter.
  - A write goes to WR; m_axi_awvalid and m_axi_wvalid rise on the next cycle, together.
  - A read goes to RD_ADDR with m_axi_arvalid = 1.
- WR:
  - Each of awvalid and wvalid drops independently in the cycle after its own ready is sampled high.
  - When both handshakes are done, go to WR_RESP with m_axi_bready = 1.
  - The slave may take awready and wready in different cycles; the block must tolerate wready arriving 1+ cycles after awready.
- WR_RESP: on bvalid, capture bresp, set rsp_rdata = 0, drop bready, go to DONE.
- RD_ADDR: on arready, drop arvalid, raise rready, go to RD_DATA.
- RD_DATA: on rvalid, capture rdata and rresp, drop rready, go to DONE.
- DONE: pulse rsp_valid[g] for exactly one cycle with the captured data and response, then return to IDLE. The earliest next grant is in the IDLE cycle.
- Throughput: at least 2 idle-to-idle overhead cycles per transaction. Back-to-back requests alternate clients when both are pending.
- Watchdog:
  - The counter increments in every WR, WR_RESP, RD_ADDR and RD_DATA cycle without progress, and clears on each handshake.
  - When it reaches TIMEOUT, drop all m_axi valid/ready outputs and set rsp_resp = 2'b10, rsp_rdata = 0 and timeout_err = 1, then go to DONE.
  - A late slave response after a timeout is ignored. The system must reset the slave.
- Slave error responses (e.g. 2'b11 for out-of-range addresses) pass through unchanged on rsp_resp; they are not timeouts.
- Requests arriving while the block is busy are held by the clients. A req_valid that drops before acceptance is simply not served.
- The block never issues a read and a write concurrently.

Test Plan:
- Single write from client 0: addr 0x10, data 0xDEADBEEF, slave accepts -> req_accept = 2'b01, then rsp_valid = 2'b01 with rsp_resp = 0 and rsp_rdata = 0. A following read from client 1 at 0x10 -> rsp_rdata = 0xDEADBEEF, rsp_resp = 0.
- Contention: both clients request reads every cycle for 6 transactions -> grant order 0,1,0,1,0,1; each rsp_valid is a single-cycle pulse matching its own accept.
- Out-of-range: client 1 writes addr 0x200 -> rsp_resp = 2'b11. A read of 0x200 -> rsp_resp = 2'b11, rsp_rdata = 0, timeout_err stays 0.
- Split handshake: slave model gives awready in cycle n and wready in cycle n+3 -> awvalid drops at n+1, wvalid drops at n+4, bready rises afterwards, and the write completes normally.
- Timeout: TIMEOUT = 8, the slave never asserts arready -> arvalid drops after 8 cycles, rsp_valid pulses with rsp_resp = 2'b10, timeout_err = 1 and stays set; the next request is served normally.
- Reset mid-read: assert m_axi_areset while in RD_DATA -> all outputs are 0 on the next edge and no rsp_valid pulse. After release, client 0 wins a tie.
